// File: rtl/reg_snapshot_streamer.sv
// reg_snapshot_streamer: captures the register bus on start and streams all or only changed
// words over valid/ready, lowest index first.
module reg_snapshot_streamer #(
    parameter int NREGS = 32,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREGS*WIDTH-1:0] registers,
    input  logic                   start,
    input  logic                   delta_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0]             out_index,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_snap [NREGS];
    logic [WIDTH-1:0] r_prev [NREGS];
    logic [NREGS-1:0] r_mask;
    logic [4:0]       r_idx;
    logic [NREGS-1:0] w_new_mask;
    logic [NREGS-1:0] w_above;
    logic             w_last;
    logic             w_fire;

    function automatic logic [4:0] f_lowest(input logic [NREGS-1:0] v);
        f_lowest = '0;
        for (int i = NREGS - 1; i >= 0; i--)
            if (v[i]) f_lowest = i[4:0];
    endfunction

    always_comb begin
        w_new_mask = '0;
        for (int i = 0; i < NREGS; i++)
            w_new_mask[i] = delta_mode ? (registers[WIDTH*i +: WIDTH] != r_prev[i]) : 1'b1;
    end

    // pending words strictly above the current one; empty means this word is the last
    assign w_above = r_mask & (({NREGS{1'b1}} << r_idx) << 1);
    assign w_last  = w_above == '0;
    assign w_fire  = r_state == SEND && out_ready;

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = start ? ((|w_new_mask) ? SEND : DONE) : IDLE;
        else if (r_state == SEND)
            w_next = (w_fire && w_last) ? DONE : SEND;
        else
            w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
            r_idx  <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_snap[i] <= '0;
                r_prev[i] <= '0;
            end
        end else begin
            if (r_state == IDLE && start) begin
                for (int i = 0; i < NREGS; i++)
                    r_snap[i] <= registers[WIDTH*i +: WIDTH];
                r_mask <= w_new_mask;
                r_idx  <= f_lowest(w_new_mask);
            end
            if (w_fire) begin
                r_mask[r_idx] <= 1'b0;
                if (!w_last) r_idx <= f_lowest(w_above);
            end
            if (r_state == DONE)
                for (int i = 0; i < NREGS; i++)
                    r_prev[i] <= r_snap[i];
        end
    end

    assign out_valid = r_state == SEND;
    assign out_index = r_idx;
    assign out_data  = r_snap[r_idx];
    assign out_last  = r_state == SEND && w_last;
    assign busy      = r_state != IDLE;
    assign done      = r_state == DONE;
endmodule

// File: tb/tb_reg_snapshot_streamer.sv
// tb_reg_snapshot_streamer: queue-based reference model of pending words checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_reg_snapshot_streamer;
    localparam int N = 32;
    localparam int W = 32;

    logic           clk = 0;
    logic           reset = 1;
    logic           start = 0;
    logic           delta_mode = 0;
    logic           out_ready = 0;
    logic [W-1:0]   regs [N];
    logic [N*W-1:0] registers;
    logic           out_valid;
    logic [4:0]     out_index;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           busy;
    logic           done;

    reg_snapshot_streamer #(.NREGS(N), .WIDTH(W)) dut (
        .clk(clk), .reset(reset), .registers(registers), .start(start),
        .delta_mode(delta_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always_comb begin
        registers = '0;
        for (int i = 0; i < N; i++) registers[W*i +: W] = regs[i];
    end

    typedef struct {logic [4:0] i; logic [W-1:0] d;} word_t;
    typedef struct {logic [4:0] i; logic [W-1:0] d; logic l;} xfer_t;

    word_t        q[$];
    xfer_t        log_q[$];
    logic [W-1:0] m_prev [N];
    logic [W-1:0] m_snap [N];
    bit           m_done = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: q holds the words still owed by the current dump, in emission order
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_done = 0;
            foreach (m_prev[i]) m_prev[i] = '0;
        end else if (m_done) begin
            m_prev = m_snap;
            m_done = 0;
        end else if (q.size() > 0) begin
            if (out_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) m_done = 1;
            end
        end else if (start) begin
            m_snap = regs;
            for (int i = 0; i < N; i++)
                if (!delta_mode || regs[i] != m_prev[i]) q.push_back('{i[4:0], regs[i]});
            m_done = q.size() == 0;
        end
    end

    always @(negedge clk) begin
        chk("valid", out_valid, q.size() > 0);
        chk("busy", busy, q.size() > 0 || m_done);
        chk("done", done, m_done);
        if (q.size() > 0) begin
            chk("index", out_index, q[0].i);
            chk("data", out_data, q[0].d);
            chk("last", out_last, q.size() == 1);
        end else
            chk("last_idle", out_last, 0);
        if (out_valid && out_ready && !reset) log_q.push_back('{out_index, out_data, out_last});
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dump(input bit dm);
        log_q.delete();
        start = 1;
        delta_mode = dm;
        step();
        start = 0;
    endtask

    task automatic wait_idle(input bit bp);
        int c = 0;
        while (busy && c < 300) begin
            if (bp) out_ready = (c % 3 == 0);
            step();
            c++;
        end
        out_ready = 1;
        chk("idle_timeout", busy, 0);
    endtask

    task automatic chk_full(input string nm);
        chk({nm, "_count"}, log_q.size(), 32);
        for (int k = 0; k < log_q.size(); k++)
            chk({nm, "_word"}, {log_q[k].l, log_q[k].i, log_q[k].d}, {k == 31, k[4:0], 32'h100 + k});
    endtask

    initial begin
        foreach (regs[i]) regs[i] = '0;
        step(2);
        reset = 0;
        chk("rst_valid", out_valid, 0);
        chk("rst_index", out_index, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        foreach (regs[i]) regs[i] = 32'h100 + i;
        out_ready = 1;
        dump(0);
        chk("full_first_valid", out_valid, 1);
        wait_idle(0);
        chk_full("full");

        dump(0);
        wait_idle(1);
        chk_full("bp");

        reset = 1;
        step();
        reset = 0;
        foreach (regs[i]) regs[i] = '0;
        regs[5] = 32'hDEAD;
        regs[17] = 32'h1;
        dump(1);
        wait_idle(0);
        chk("delta_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("delta_w0", {log_q[0].l, log_q[0].i, log_q[0].d}, {1'b0, 5'd5, 32'hDEAD});
            chk("delta_w1", {log_q[1].l, log_q[1].i, log_q[1].d}, {1'b1, 5'd17, 32'h1});
        end
        dump(1);
        chk("empty_done", done, 1);
        chk("empty_valid", out_valid, 0);
        wait_idle(0);
        chk("empty_count", log_q.size(), 0);

        regs[3] = 32'hA;
        dump(0);
        regs[3] = 32'hB;
        wait_idle(0);
        chk("atomic_count", log_q.size(), 32);
        if (log_q.size() == 32) chk("atomic_r3", log_q[3].d, 32'hA);

        foreach (regs[i]) regs[i] = i;
        dump(0);
        step(3);
        start = 1;
        step();
        start = 0;
        step(6);
        reset = 1;
        step();
        chk("abort_valid", out_valid, 0);
        reset = 0;
        chk("abort_done", done, 0);
        chk("abort_count", log_q.size(), 10);
        if (log_q.size() == 10) chk("abort_w9", {log_q[9].i, log_q[9].d}, {5'd9, 32'd9});
        dump(1);
        wait_idle(0);
        chk("post_rst_count", log_q.size(), 31);
        if (log_q.size() == 31) begin
            chk("post_rst_first", log_q[0].i, 1);
            chk("post_rst_last", {log_q[30].l, log_q[30].i}, {1'b1, 5'd31});
        end

        regs[31] = 32'hFFFF_0000;
        dump(1);
        chk("b31_valid", out_valid, 1);
        chk("b31_last", out_last, 1);
        wait_idle(0);
        chk("b31_count", log_q.size(), 1);
        if (log_q.size() == 1) chk("b31_word", {log_q[0].l, log_q[0].i, log_q[0].d}, {1'b1, 5'd31, 32'hFFFF_0000});

        repeat (2000) begin
            out_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, N - 1)] = $urandom_range(0, 3);
            start = $urandom_range(0, 9) == 0;
            delta_mode = $urandom_range(0, 1) == 1;
            reset = $urandom_range(0, 299) == 0;
            step();
        end
        reset = 0;
        start = 0;
        out_ready = 1;
        step(40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
